boot_loader: RTL

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/boot_loader.sv
// Serial boot loader: takes a length-prefixed, checksummed frame of 16-bit words,
// writes them to instruction memory in order, then releases the CPU from reset.
module boot_loader #(
    parameter int TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        reload,
    output logic [9:0]  imem_addr,
    output logic [15:0] imem_wdata,
    output logic        imem_wr,
    output logic        cpu_rst,
    output logic        busy,
    output logic        err,
    output logic [2:0]  dbg_state
);

    // rx_valid is a one-cycle strobe with no backpressure: a byte is taken in any
    // cycle it is high while a frame is being collected, and is lost otherwise.
    typedef enum logic [2:0] {
        S_LEN_LO  = 3'd0,
        S_LEN_HI  = 3'd1,
        S_INSN_HI = 3'd2,
        S_INSN_LO = 3'd3,
        S_CHK     = 3'd4,
        S_RUN     = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    localparam int IW = $clog2(TIMEOUT + 1);

    state_t        state_q;
    logic [7:0]    len_lo_q;
    logic [7:0]    hi_q;
    logic [7:0]    sum_q;
    logic [10:0]   len_q;
    logic [10:0]   cnt_q;
    logic [IW-1:0] idle_q;
    logic [9:0]    addr_q;
    logic [15:0]   wdata_q;
    logic          wr_q;
    logic          cpu_rst_q;
    logic          busy_q;
    logic          err_q;

    logic [15:0]   len_d;
    logic [7:0]    sum_d;
    logic [10:0]   cnt_d;
    logic [IW-1:0] idle_d;
    logic          idle_active;
    logic          timeout_hit;

    assign len_d       = {rx_data, len_lo_q};
    assign sum_d       = sum_q + rx_data;
    assign cnt_d       = cnt_q + 11'd1;
    assign idle_d      = idle_q + IW'(1);
    assign idle_active = (state_q == S_LEN_HI) || (state_q == S_INSN_HI) ||
                         (state_q == S_INSN_LO) || (state_q == S_CHK);
    // A byte arriving in the last allowed idle cycle wins over the timeout.
    assign timeout_hit = idle_active && !rx_valid && (idle_d == IW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_LEN_LO;
            len_lo_q  <= '0;
            hi_q      <= '0;
            sum_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            idle_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
        end else if (reload) begin
            state_q   <= S_LEN_LO;
            sum_q     <= '0;
            cnt_q     <= '0;
            idle_q    <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            wr_q      <= 1'b0;
            cpu_rst_q <= (state_q != S_RUN);
            // Address moves on after each write except the last, so it never wraps.
            if (wr_q && (cnt_q != len_q)) begin
                addr_q <= addr_q + 10'd1;
            end
            if (idle_active) begin
                idle_q <= rx_valid ? '0 : idle_d;
            end
            if (timeout_hit) begin
                state_q <= S_ERR;
                idle_q  <= '0;
                busy_q  <= 1'b0;
                err_q   <= 1'b1;
            end else if (rx_valid) begin
                case (state_q)
                    S_LEN_LO: begin
                        len_lo_q <= rx_data;
                        sum_q    <= sum_d;
                        state_q  <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        sum_q <= sum_d;
                        len_q <= len_d[10:0];
                        cnt_q <= '0;
                        if (len_d > 16'd1024) begin
                            state_q <= S_ERR;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else if (len_d == 16'd0) begin
                            state_q <= S_CHK;
                        end else begin
                            state_q <= S_INSN_HI;
                        end
                    end
                    S_INSN_HI: begin
                        hi_q    <= rx_data;
                        sum_q   <= sum_d;
                        state_q <= S_INSN_LO;
                    end
                    S_INSN_LO: begin
                        sum_q   <= sum_d;
                        wr_q    <= 1'b1;
                        wdata_q <= {hi_q, rx_data};
                        cnt_q   <= cnt_d;
                        state_q <= (cnt_d == len_q) ? S_CHK : S_INSN_HI;
                    end
                    S_CHK: begin
                        busy_q <= 1'b0;
                        if (rx_data == sum_q) begin
                            state_q <= S_RUN;
                            err_q   <= 1'b0;
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign imem_wr    = wr_q;
    assign cpu_rst    = cpu_rst_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign dbg_state  = state_q;

endmodule
